fp_align_stage: RTL

- Operand-alignment front end of the floating-point adder datapath.
- Accepts two IEEE-754 single-precision operands and orders them by magnitude.
- Computes the saturated exponent difference and presents the smaller operand's fraction, shift amount and fill bit directly to the right barrel shifter.
- Two-stage pipeline with valid/ready handshakes on both sides; the larger operand and its sign/exponent travel alongside to the downstream add/normalise stage.

---
 rtl/fp_align_stage_if.sv | 50 +++++
 rtl/fp_align_stage.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/fp_align_stage_if.sv
// rtl/fp_align_stage_if.sv - operand/bundle bus for the FP adder alignment stage
//
// Purpose: groups the upstream operand handshake and the downstream aligned
// bundle handshake of fp_align_stage into one bus.
// Signals:
//   A_in, B_in, In_valid, In_ready   upstream operand transfer
//   Out_valid, Out_ready             downstream bundle transfer
//   SmallFrac, ExpDiff, ShiftEnable  smaller operand, ready for the right shifter
//   LargeFrac, LargeHidden, LargeExp larger operand for the add/normalise stage
//   ResultSign, EffSub, Swapped      sign/ordering information
//   IsNaN, IsInf                     special-operand flags
// Modports: slave = the alignment stage, master = its environment.
interface fp_align_stage_if #(
   parameter int N       = 32,
   parameter int EXP_W   = 8,
   parameter int FRAC_W  = N - 9,
   parameter int SHAMT_W = $clog2(N)
);
   logic [N-1:0]       A_in;
   logic [N-1:0]       B_in;
   logic               In_valid;
   logic               In_ready;
   logic               Out_valid;
   logic               Out_ready;
   logic [FRAC_W-1:0]  SmallFrac;
   logic [SHAMT_W-1:0] ExpDiff;
   logic               ShiftEnable;
   logic [FRAC_W-1:0]  LargeFrac;
   logic               LargeHidden;
   logic [EXP_W-1:0]   LargeExp;
   logic               ResultSign;
   logic               EffSub;
   logic               Swapped;
   logic               IsNaN;
   logic               IsInf;

   modport slave (
      input  A_in, B_in, In_valid, Out_ready,
      output In_ready, Out_valid, SmallFrac, ExpDiff, ShiftEnable,
             LargeFrac, LargeHidden, LargeExp, ResultSign, EffSub,
             Swapped, IsNaN, IsInf
   );

   modport master (
      output A_in, B_in, In_valid, Out_ready,
      input  In_ready, Out_valid, SmallFrac, ExpDiff, ShiftEnable,
             LargeFrac, LargeHidden, LargeExp, ResultSign, EffSub,
             Swapped, IsNaN, IsInf
   );
endinterface

// File: rtl/fp_align_stage.sv
// rtl/fp_align_stage.sv - two-stage operand ordering/alignment front end of the FP adder
//
// Purpose: orders two IEEE-754 single operands by magnitude (stage 1), then
// forms the saturated exponent difference and routes the smaller fraction,
// shift amount and fill bit to the right barrel shifter (stage 2).
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset; clears both stages and all outputs
//   bus      fp_align_stage_if slave: operand handshake in, bundle handshake out
module fp_align_stage #(
   parameter int N       = 32,
   parameter int EXP_W   = 8,
   parameter int FRAC_W  = N - 9,
   parameter int SHAMT_W = $clog2(N)
) (
   input logic            clk,
   input logic            reset_n,
   fp_align_stage_if.slave bus
);
   localparam logic [EXP_W-1:0] EXP_ONES = '1;
   localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
   localparam logic [EXP_W-1:0] SAT_MAX  = EXP_W'(2**SHAMT_W - 1);
   localparam int               MAG_W    = EXP_W + 1 + FRAC_W;

   // ---------------- operand unpack (combinational) ----------------
   logic              sign_a, sign_b, hid_a, hid_b, b_larger;
   logic [EXP_W-1:0]  exp_a, exp_b, eff_a, eff_b;
   logic [FRAC_W-1:0] frac_a, frac_b;
   logic [MAG_W-1:0]  mag_a, mag_b;

   assign sign_a = bus.A_in[N-1];
   assign sign_b = bus.B_in[N-1];
   assign exp_a  = bus.A_in[N-2 -: EXP_W];
   assign exp_b  = bus.B_in[N-2 -: EXP_W];
   assign frac_a = bus.A_in[FRAC_W-1:0];
   assign frac_b = bus.B_in[FRAC_W-1:0];
   assign hid_a  = (exp_a != '0);
   assign hid_b  = (exp_b != '0);
   // Denormals share the exponent of the smallest normal; the missing hidden
   // bit keeps them ordered below it.
   assign eff_a  = hid_a ? exp_a : EXP_ONE;
   assign eff_b  = hid_b ? exp_b : EXP_ONE;
   assign mag_a  = {eff_a, hid_a, frac_a};
   assign mag_b  = {eff_b, hid_b, frac_b};
   // Strict compare: equal magnitudes (including +0/-0) keep A as larger.
   assign b_larger = (mag_b > mag_a);

   // ---------------- handshake ----------------
   logic s1_valid, s2_valid, s2_advance, accept, move;

   assign s2_advance   = !s2_valid || bus.Out_ready;
   assign bus.In_ready = !s1_valid || s2_advance;
   assign accept       = bus.In_valid && bus.In_ready;
   assign move         = s1_valid && s2_advance;

   // ---------------- stage 1 ----------------
   logic              s1_swapped, s1_sign_a, s1_sign_b, s1_l_sign;
   logic              s1_l_hid, s1_s_hid;
   logic [EXP_W-1:0]  s1_l_exp, s1_l_eff, s1_s_eff;
   logic [FRAC_W-1:0] s1_l_frac, s1_s_frac;
   logic [1:0]        s1_nan, s1_inf;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid   <= 1'b0;
         s1_swapped <= 1'b0;
         s1_sign_a  <= 1'b0;
         s1_sign_b  <= 1'b0;
         s1_l_sign  <= 1'b0;
         s1_l_hid   <= 1'b0;
         s1_s_hid   <= 1'b0;
         s1_l_exp   <= '0;
         s1_l_eff   <= '0;
         s1_s_eff   <= '0;
         s1_l_frac  <= '0;
         s1_s_frac  <= '0;
         s1_nan     <= '0;
         s1_inf     <= '0;
      end else begin
         if (accept) begin
            s1_valid   <= 1'b1;
            s1_swapped <= b_larger;
            s1_sign_a  <= sign_a;
            s1_sign_b  <= sign_b;
            s1_l_sign  <= b_larger ? sign_b : sign_a;
            s1_l_hid   <= b_larger ? hid_b  : hid_a;
            s1_s_hid   <= b_larger ? hid_a  : hid_b;
            s1_l_exp   <= b_larger ? exp_b  : exp_a;
            s1_l_eff   <= b_larger ? eff_b  : eff_a;
            s1_s_eff   <= b_larger ? eff_a  : eff_b;
            s1_l_frac  <= b_larger ? frac_b : frac_a;
            s1_s_frac  <= b_larger ? frac_a : frac_b;
            s1_nan     <= {(exp_b == EXP_ONES) && (frac_b != '0),
                           (exp_a == EXP_ONES) && (frac_a != '0)};
            s1_inf     <= {(exp_b == EXP_ONES) && (frac_b == '0),
                           (exp_a == EXP_ONES) && (frac_a == '0)};
         end else if (move) begin
            s1_valid <= 1'b0;
         end
      end
   end

   // ---------------- stage 2 ----------------
   logic [EXP_W-1:0]   raw_diff;
   logic [SHAMT_W-1:0] sat_diff;
   logic               any_nan;

   // Large was chosen by magnitude, so its effective exponent is never smaller.
   assign raw_diff = s1_l_eff - s1_s_eff;
   assign sat_diff = (raw_diff > SAT_MAX) ? SAT_MAX[SHAMT_W-1:0] : raw_diff[SHAMT_W-1:0];
   assign any_nan  = |s1_nan;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s2_valid        <= 1'b0;
         bus.SmallFrac   <= '0;
         bus.ExpDiff     <= '0;
         bus.ShiftEnable <= 1'b0;
         bus.LargeFrac   <= '0;
         bus.LargeHidden <= 1'b0;
         bus.LargeExp    <= '0;
         bus.ResultSign  <= 1'b0;
         bus.EffSub      <= 1'b0;
         bus.Swapped     <= 1'b0;
         bus.IsNaN       <= 1'b0;
         bus.IsInf       <= 1'b0;
      end else if (s2_advance) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            bus.SmallFrac   <= s1_s_frac;
            bus.ExpDiff     <= sat_diff;
            bus.ShiftEnable <= s1_s_hid;
            bus.LargeFrac   <= s1_l_frac;
            bus.LargeHidden <= s1_l_hid;
            bus.LargeExp    <= s1_l_exp;
            bus.ResultSign  <= s1_l_sign;
            bus.EffSub      <= s1_sign_a ^ s1_sign_b;
            bus.Swapped     <= s1_swapped;
            bus.IsNaN       <= any_nan;
            bus.IsInf       <= (|s1_inf) && !any_nan;
         end
      end
   end

   assign bus.Out_valid = s2_valid;
endmodule
